// File: rtl/mdu_pkg.sv
// Purpose: shared encodings for the multiply/divide unit (op codes, FSM states, counter sizing).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit_iter_core.sv
// Purpose: one iteration of the magnitude datapath: shift-add multiply or restoring shift-subtract divide.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the step.
// Ports: is_div selects divide; acc_hi/acc_lo are the current accumulator halves,
//        operand is |src_b|; next_hi/next_lo are the accumulator after one step.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        // Multiply: acc_lo holds the not-yet-consumed multiplier bits; the
        // extra sum bit catches the carry before the right shift.
        sum     = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : {WIDTH{1'b0}})};
        // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend
        // out the top while quotient bits enter at the bottom.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        fits    = (shifted >= {1'b0, operand});

        next_hi = {sum[WIDTH:1]};
        next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            next_hi = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency: done WIDTH+1 cycles after accept (1 cycle for divide by zero); next start accepted in the done cycle.
// Backpressure: busy stalls the pipeline; start while busy is dropped, hilo_we while busy is ignored.
// Ports: start/op/src_a/src_b request an op; hilo_we/hilo_wdata implement MTHI/MTLO;
//        busy, done (1-cycle pulse), div_by_zero (valid with done, sticky) and hi/lo are outputs.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic             sign_a_q, sign_b_q, zero_div_q;
    logic [WIDTH-1:0] mag_b_q, acc_hi_q, acc_lo_q;
    logic [CW-1:0]    cnt_q;

    // Accept-side decode of the incoming request.
    logic             in_signed, in_div, in_zero_div;
    logic [WIDTH-1:0] in_mag_a, in_mag_b;

    assign in_signed   = (op == OP_MULT) || (op == OP_DIV);
    assign in_div      = (op == OP_DIV)  || (op == OP_DIVU);
    assign in_zero_div = in_div && (src_b == '0);
    // -0x80..0 wraps back to 0x80..0, which is the correct unsigned magnitude.
    assign in_mag_a    = (in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign in_mag_b    = (in_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    logic [WIDTH-1:0] step_hi, step_lo;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div  (op_q[1]),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (mag_b_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign fix-up applied on the FIX edge. sign_a_q/sign_b_q are already
    // zero for unsigned ops, so no op check is needed for the negations.
    logic             neg_res;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign neg_res = sign_a_q ^ sign_b_q;

    always_comb begin
        fix_hi = acc_hi_q;
        fix_lo = acc_lo_q;
        if (zero_div_q) begin
            // acc_lo still holds |src_a|; rebuild the original rs value.
            fix_lo = '1;
            fix_hi = sign_a_q ? -acc_lo_q : acc_lo_q;
        end else if (!op_q[1]) begin
            if (neg_res) begin
                {fix_hi, fix_lo} = -{acc_hi_q, acc_lo_q};
            end
        end else begin
            if (neg_res) begin
                fix_lo = -acc_lo_q;
            end
            if (sign_a_q) begin
                fix_hi = -acc_hi_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = in_zero_div ? FIX : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                // Counter reaches 0 on this edge.
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_MULT;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            zero_div_q  <= 1'b0;
            mag_b_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            cnt_q       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (hilo_we[1]) begin
                        hi <= hilo_wdata;
                    end
                    if (hilo_we[0]) begin
                        lo <= hilo_wdata;
                    end
                    if (start || (hilo_we != 2'b00)) begin
                        div_by_zero <= 1'b0;
                    end
                    if (start) begin
                        op_q       <= op;
                        sign_a_q   <= in_signed & src_a[WIDTH-1];
                        sign_b_q   <= in_signed & src_b[WIDTH-1];
                        zero_div_q <= in_zero_div;
                        mag_b_q    <= in_mag_b;
                        acc_hi_q   <= '0;
                        acc_lo_q   <= in_mag_a;
                        cnt_q      <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q - CW'(1);
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    div_by_zero <= zero_div_q;
                end
                default: ;
            endcase
        end
    end

endmodule
